fpu_dispatch: RTL and testbench

Request dispatcher directly upstream of `fpu16`. Accepts operation requests over a valid/ready interface, buffers them in a small FIFO, and sequences each one onto the `fpu16` operand, op, reset and start pins. It waits the required hold time for ADD/SUB, or for `mulDone` for MUL, then returns a tagged result with status flags over a valid/ready response interface. It replaces hand-timed operand driving with a single in-order issue point.

---
 rtl/fpu_lib.sv | 39 +++
 rtl/fpu_req_fifo.sv | 41 ++++
 rtl/fpu_dispatch.sv | 170 +++++++++++++++++
 tb/tb_fpu_dispatch.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_lib.sv
// Shared fp16 FPU types: operands, op codes, status flags and dispatcher states.
package fpu_lib;

  typedef logic [15:0] fp16_t;

  typedef enum logic [1:0] {
    FPU_ADD = 2'd0,
    FPU_SUB = 2'd1,
    FPU_MUL = 2'd2
  } fpuOp_t;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } statusFlag_t;

  typedef enum logic [2:0] {
    IDLE,
    ARITH_HOLD,
    MUL_RST,
    MUL_START,
    MUL_WAIT,
    RESP
  } dispatchState_t;

  localparam fp16_t FPU_QNAN = 16'h7E00;

  // Flags reported for anything the dispatcher refuses or abandons.
  function automatic statusFlag_t invalidFlags();
    statusFlag_t f;
    f    = '0;
    f.nv = 1'b1;
    return f;
  endfunction

endpackage

// File: rtl/fpu_req_fifo.sv
// Request FIFO; pointers carry one extra wrap bit so full and empty stay distinct.
module fpu_req_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [7:0]
) (
  input  logic clock,
  input  logic reset,
  input  logic push,
  input  T     pushData,
  input  logic pop,
  output logic full,
  output logic empty,
  output T     head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  T            mem [DEPTH];
  logic [AW:0] wrPtr;
  logic [AW:0] rdPtr;

  assign empty = (wrPtr == rdPtr);
  assign full  = (wrPtr[AW-1:0] == rdPtr[AW-1:0]) && (wrPtr[AW] != rdPtr[AW]);
  assign head  = mem[rdPtr[AW-1:0]];

  always_ff @(posedge clock) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (push && !full) wrPtr <= wrPtr + PTR_ONE;
      if (pop && !empty) rdPtr <= rdPtr + PTR_ONE;
    end
  end

  always_ff @(posedge clock) begin
    if (push && !full) mem[wrPtr[AW-1:0]] <= pushData;
  end

endmodule

// File: rtl/fpu_dispatch.sv
// In-order request dispatcher in front of fpu16: queues tagged requests, drives
// operands/op/reset/start, and returns one tagged result at a time.
module fpu_dispatch
  import fpu_lib::*;
#(
  parameter int DEPTH       = 4,
  parameter int ADD_HOLD    = 2,
  parameter int MUL_TIMEOUT = 64,
  parameter int TAG_W       = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              reqValid,
  output logic              reqReady,
  input  fp16_t             reqIn1,
  input  fp16_t             reqIn2,
  input  fpuOp_t            reqOp,
  output logic [TAG_W-1:0]  reqTag,
  output fp16_t             fpuIn1,
  output fp16_t             fpuIn2,
  output fpuOp_t            op,
  output logic              fpuReset,
  output logic              start,
  input  logic              mulDone,
  input  fp16_t             fpuOut,
  input  statusFlag_t       statusFlags,
  output logic              rspValid,
  input  logic              rspReady,
  output fp16_t             rspResult,
  output statusFlag_t       rspFlags,
  output logic [TAG_W-1:0]  rspTag,
  output logic              rspTimeout
);

  typedef struct packed {
    fp16_t            in1;
    fp16_t            in2;
    fpuOp_t           op;
    logic [TAG_W-1:0] tag;
  } fpuReq_t;

  localparam int HOLD_W = (ADD_HOLD > 1) ? $clog2(ADD_HOLD) : 1;
  localparam int TO_W   = (MUL_TIMEOUT > 1) ? $clog2(MUL_TIMEOUT) : 1;
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(ADD_HOLD - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = 1;
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(MUL_TIMEOUT - 1);
  localparam logic [TO_W-1:0]   TO_ONE    = 1;
  localparam logic [TAG_W-1:0]  TAG_ONE   = 1;

  dispatchState_t    state;
  logic [HOLD_W-1:0] holdCnt;
  logic [TO_W-1:0]   toCnt;
  logic [TAG_W-1:0]  curTag;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  fpuReq_t           pushReq;
  fpuReq_t           headReq;

  assign reqReady = !full;
  assign push     = reqValid && !full;
  assign pop      = (state == IDLE) && !empty;
  assign fpuReset = reset || (state == MUL_RST);
  assign start    = (state == MUL_START);
  assign rspValid = (state == RESP);

  always_comb begin
    pushReq     = '0;
    pushReq.in1 = reqIn1;
    pushReq.in2 = reqIn2;
    pushReq.op  = reqOp;
    pushReq.tag = reqTag;
  end

  fpu_req_fifo #(
    .DEPTH (DEPTH),
    .T     (fpuReq_t)
  ) reqFifo (
    .clock    (clock),
    .reset    (reset),
    .push     (push),
    .pushData (pushReq),
    .pop      (pop),
    .full     (full),
    .empty    (empty),
    .head     (headReq)
  );

  always_ff @(posedge clock) begin
    if (reset) reqTag <= '0;
    else if (push) reqTag <= reqTag + TAG_ONE;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      fpuIn1     <= '0;
      fpuIn2     <= '0;
      op         <= FPU_ADD;
      curTag     <= '0;
      holdCnt    <= '0;
      toCnt      <= '0;
      rspResult  <= '0;
      rspFlags   <= '0;
      rspTag     <= '0;
      rspTimeout <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!empty) begin
            fpuIn1     <= headReq.in1;
            fpuIn2     <= headReq.in2;
            op         <= headReq.op;
            curTag     <= headReq.tag;
            rspTimeout <= 1'b0;
            case (headReq.op)
              FPU_ADD, FPU_SUB: begin
                holdCnt <= HOLD_INIT;
                state   <= ARITH_HOLD;
              end
              FPU_MUL: state <= MUL_RST;
              default: begin
                rspResult <= FPU_QNAN;
                rspFlags  <= invalidFlags();
                rspTag    <= headReq.tag;
                state     <= RESP;
              end
            endcase
          end
        end
        ARITH_HOLD: begin
          if (holdCnt == '0) begin
            rspResult <= fpuOut;
            rspFlags  <= statusFlags;
            rspTag    <= curTag;
            state     <= RESP;
          end else begin
            holdCnt <= holdCnt - HOLD_ONE;
          end
        end
        MUL_RST: state <= MUL_START;
        MUL_START: begin
          toCnt <= '0;
          state <= MUL_WAIT;
        end
        MUL_WAIT: begin
          // The cycle holding count MUL_TIMEOUT-1 is the last one mulDone may arrive in.
          if (mulDone) begin
            rspResult <= fpuOut;
            rspFlags  <= statusFlags;
            rspTag    <= curTag;
            state     <= RESP;
          end else if (toCnt == TO_LAST) begin
            rspResult  <= FPU_QNAN;
            rspFlags   <= invalidFlags();
            rspTag     <= curTag;
            rspTimeout <= 1'b1;
            state      <= RESP;
          end else begin
            toCnt <= toCnt + TO_ONE;
          end
        end
        RESP: if (rspReady) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_dispatch.sv
// Bench for fpu_dispatch: stub fpu16 plus an in-order expectation queue and cycle-count checks.
module tb_fpu_dispatch;
  import fpu_lib::*;

  localparam int DEPTH       = 4;
  localparam int ADD_HOLD    = 2;
  localparam int MUL_TIMEOUT = 64;
  localparam int TAG_W       = 3;

  typedef struct {
    fp16_t      res;
    logic [4:0] flg;
    int         tag;
    logic       to;
  } exp_t;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             reqValid = 1'b0;
  logic             reqReady;
  fp16_t            reqIn1 = '0;
  fp16_t            reqIn2 = '0;
  fpuOp_t           reqOp = FPU_ADD;
  logic [TAG_W-1:0] reqTag;
  fp16_t            fpuIn1;
  fp16_t            fpuIn2;
  fpuOp_t           op;
  logic             fpuReset;
  logic             start;
  logic             mulDone;
  fp16_t            fpuOut;
  statusFlag_t      statusFlags;
  logic             rspValid;
  logic             rspReady = 1'b0;
  fp16_t            rspResult;
  statusFlag_t      rspFlags;
  logic [TAG_W-1:0] rspTag;
  logic             rspTimeout;

  int   checks = 0;
  int   errors = 0;
  int   mulLat = 3;   // 0 means the stub never raises mulDone
  int   tagModel = 0;
  exp_t expQ[$];
  int   mcnt;
  logic armed;

  fpu_dispatch #(
    .DEPTH       (DEPTH),
    .ADD_HOLD    (ADD_HOLD),
    .MUL_TIMEOUT (MUL_TIMEOUT),
    .TAG_W       (TAG_W)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .reqValid    (reqValid),
    .reqReady    (reqReady),
    .reqIn1      (reqIn1),
    .reqIn2      (reqIn2),
    .reqOp       (reqOp),
    .reqTag      (reqTag),
    .fpuIn1      (fpuIn1),
    .fpuIn2      (fpuIn2),
    .op          (op),
    .fpuReset    (fpuReset),
    .start       (start),
    .mulDone     (mulDone),
    .fpuOut      (fpuOut),
    .statusFlags (statusFlags),
    .rspValid    (rspValid),
    .rspReady    (rspReady),
    .rspResult   (rspResult),
    .rspFlags    (rspFlags),
    .rspTag      (rspTag),
    .rspTimeout  (rspTimeout)
  );

  always #5 clock = ~clock;

  function automatic logic known(input logic [1:0] o, input fp16_t a, input fp16_t b);
    return (o == 2'd0 && a == 16'h3c00 && b == 16'h4000) ||
           (o == 2'd1 && a == 16'h4200 && b == 16'h3c00) ||
           (o == 2'd2 && a == 16'h4000 && b == 16'h4200);
  endfunction

  // Stand-in fpu16 arithmetic: real fp16 results for the directed pairs, arbitrary but fixed otherwise.
  function automatic fp16_t fakeRes(input logic [1:0] o, input fp16_t a, input fp16_t b);
    if (o == 2'd0 && a == 16'h3c00 && b == 16'h4000) return 16'h4200;
    if (o == 2'd1 && a == 16'h4200 && b == 16'h3c00) return 16'h4000;
    if (o == 2'd2 && a == 16'h4000 && b == 16'h4200) return 16'h4600;
    case (o)
      2'd0:    return a + b;
      2'd1:    return a - b;
      default: return a ^ {b[7:0], b[15:8]};
    endcase
  endfunction

  function automatic logic [4:0] fakeFlg(input logic [1:0] o, input fp16_t a, input fp16_t b);
    if (known(o, a, b)) return 5'b0;
    return {a[0] ^ b[1], a[2], b[3] ^ o[0], a[5] ^ b[4], a[7] ^ o[1]};
  endfunction

  always_comb begin
    fpuOut      = fakeRes(2'(op), fpuIn1, fpuIn2);
    statusFlags = statusFlag_t'(fakeFlg(2'(op), fpuIn1, fpuIn2));
  end

  always @(posedge clock) begin
    mulDone <= 1'b0;
    if (fpuReset) armed <= 1'b0;
    else if (start) begin
      armed <= 1'b1;
      mcnt  <= 0;
    end else if (armed) begin
      mcnt <= mcnt + 1;
      if (mulLat > 0 && mcnt + 1 == mulLat) begin
        mulDone <= 1'b1;
        armed   <= 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t mkExp(input fp16_t a, input fp16_t b, input logic [1:0] o, input int tag);
    exp_t e;
    e.tag = tag;
    e.to  = 1'b0;
    if (o == 2'd3) begin
      e.res = 16'h7E00;
      e.flg = 5'b10000;
    end else if (o == 2'd2 && mulLat <= 0) begin
      e.res = 16'h7E00;
      e.flg = 5'b10000;
      e.to  = 1'b1;
    end else begin
      e.res = fakeRes(o, a, b);
      e.flg = fakeFlg(o, a, b);
    end
    return e;
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input fp16_t a, input fp16_t b, input logic [1:0] opc);
    int n;
    reqIn1   = a;
    reqIn2   = b;
    reqOp    = fpuOp_t'(opc);
    reqValid = 1'b1;
    n = 0;
    while (!reqReady && n < 200) begin
      @(negedge clock);
      n++;
    end
    chk("req_ready_bound", reqReady, 1'b1);
    if (reqReady) begin
      chk("req_tag", reqTag, tagModel);
      expQ.push_back(mkExp(a, b, opc, tagModel));
      tagModel = (tagModel + 1) % (1 << TAG_W);
    end
    @(negedge clock);
    reqValid = 1'b0;
  endtask

  task automatic getResp();
    int   n;
    exp_t e;
    n = 0;
    while (!rspValid && n < 200) begin
      @(negedge clock);
      n++;
    end
    chk("rsp_valid_bound", rspValid, 1'b1);
    if (rspValid) begin
      chk("rsp_expected", expQ.size() != 0, 1'b1);
      if (expQ.size() != 0) begin
        e = expQ.pop_front();
        chk("rsp_result", rspResult, e.res);
        chk("rsp_flags", rspFlags, e.flg);
        chk("rsp_tag", rspTag, e.tag);
        chk("rsp_timeout", rspTimeout, e.to);
      end
      rspReady = 1'b1;
      @(negedge clock);
      rspReady = 1'b0;
      chk("rsp_drop", rspValid, 1'b0);
    end
  endtask

  // One request on an idle block, with cycle positions counted from the accepting cycle.
  task automatic timedOp(input fp16_t a, input fp16_t b, input logic [1:0] opc);
    int k, kRst, kStart, kDone, kRsp, nRst, nStart;
    send(a, b, opc);
    k = 1; kRst = -1; kStart = -1; kDone = -1; kRsp = -1; nRst = 0; nStart = 0;
    while (k < 200) begin
      if (fpuReset) begin nRst++; kRst = k; end
      if (start) begin nStart++; kStart = k; end
      if (mulDone && kDone < 0) kDone = k;
      if (rspValid) begin
        kRsp = k;
        break;
      end
      @(negedge clock);
      k++;
    end
    chk("rsp_within_bound", kRsp > 0, 1'b1);
    case (opc)
      2'd0, 2'd1: begin
        chk("arith_latency", kRsp, ADD_HOLD + 2);
        chk("arith_no_reset", nRst, 0);
        chk("arith_no_start", nStart, 0);
      end
      2'd2: begin
        chk("mul_reset_count", nRst, 1);
        chk("mul_reset_cycle", kRst, 2);
        chk("mul_start_count", nStart, 1);
        chk("mul_start_cycle", kStart, 3);
        if (mulLat <= 0) chk("mul_timeout_latency", kRsp, 4 + MUL_TIMEOUT);
        else chk("mul_done_latency", kRsp, kDone + 1);
      end
      default: chk("bad_op_latency", kRsp, 2);
    endcase
    getResp();
  endtask

  fp16_t      tblA [6] = '{16'h3c00, 16'h4200, 16'h4000, 16'h1234, 16'habcd, 16'h7777};
  fp16_t      tblB [6] = '{16'h4000, 16'h3c00, 16'h4200, 16'h5678, 16'h0102, 16'h1111};
  logic [1:0] tblO [6] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd2, 2'd1};

  initial begin
    int acc, nV, nS;
    logic blocked;

    repeat (3) @(negedge clock);
    chk("reset_fpuReset_held", fpuReset, 1'b1);
    reset = 1'b0;
    @(negedge clock);
    chk("reset_reqReady", reqReady, 1'b1);
    chk("reset_reqTag", reqTag, 0);
    chk("reset_fpuIn1", fpuIn1, 0);
    chk("reset_fpuIn2", fpuIn2, 0);
    chk("reset_op", op, FPU_ADD);
    chk("reset_fpuReset_rel", fpuReset, 1'b0);
    chk("reset_start", start, 1'b0);
    chk("reset_rspValid", rspValid, 1'b0);
    chk("reset_rspResult", rspResult, 0);
    chk("reset_rspFlags", rspFlags, 0);
    chk("reset_rspTag", rspTag, 0);
    chk("reset_rspTimeout", rspTimeout, 1'b0);

    mulLat = 3;
    timedOp(16'h3c00, 16'h4000, 2'd0);
    timedOp(16'h4000, 16'h4200, 2'd2);

    // Backlog with the consumer stalled: one request in flight plus DEPTH queued.
    mulLat = 2;
    acc = 0;
    blocked = 1'b0;
    for (int i = 0; i < 6 && !blocked; i++) begin
      reqIn1   = tblA[i];
      reqIn2   = tblB[i];
      reqOp    = fpuOp_t'(tblO[i]);
      reqValid = 1'b1;
      if (reqReady) begin
        chk("backlog_tag", reqTag, tagModel);
        expQ.push_back(mkExp(tblA[i], tblB[i], tblO[i], tagModel));
        tagModel = (tagModel + 1) % (1 << TAG_W);
        acc++;
        @(negedge clock);
      end else begin
        blocked = 1'b1;
      end
    end
    reqValid = 1'b0;
    chk("backlog_accepts", acc, DEPTH + 1);
    chk("backlog_reqReady_low", reqReady, 1'b0);
    repeat (acc) getResp();
    chk("backlog_drained", expQ.size(), 0);
    for (int i = acc; i < 6; i++) begin
      send(tblA[i], tblB[i], tblO[i]);
      getResp();
    end

    mulLat = 0;
    timedOp(16'($urandom), 16'($urandom), 2'd2);
    mulLat = 3;
    timedOp(16'h3c00, 16'h4000, 2'd0);

    // Reset during MUL_WAIT with three requests queued behind it.
    mulLat = 0;
    send(16'h4000, 16'h4200, 2'd2);
    send(16'h3c00, 16'h4000, 2'd0);
    send(16'h1111, 16'h2222, 2'd0);
    send(16'h3333, 16'h4444, 2'd1);
    repeat (3) @(negedge clock);
    chk("pre_reset_busy", rspValid, 1'b0);
    chk("pre_reset_full_q", reqReady, 1'b1);
    reset = 1'b1;
    @(negedge clock);
    chk("midop_fpuReset", fpuReset, 1'b1);
    reset = 1'b0;
    chk("midop_rspValid", rspValid, 1'b0);
    chk("midop_reqReady", reqReady, 1'b1);
    chk("midop_reqTag", reqTag, 0);
    expQ.delete();
    tagModel = 0;
    mulLat = 3;
    rspReady = 1'b1;
    nV = 0;
    nS = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (rspValid) nV++;
      if (start) nS++;
    end
    rspReady = 1'b0;
    chk("midop_no_stale_rsp", nV, 0);
    chk("midop_no_start", nS, 0);

    // Random single requests; twelve of them walk the tag through its wrap.
    for (int i = 0; i < 12; i++) begin
      mulLat = $urandom_range(1, 6);
      timedOp(16'($urandom), 16'($urandom), 2'($urandom_range(0, 3)));
    end
    chk("final_queue_empty", expQ.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
